// File: rtl/serial_subtractor_if.sv
// Handshake/data bundle for serial_subtractor; the ovf signal exists only when SUB_OVF_EN is defined.
interface serial_subtractor_if #(parameter int N = 4);
  logic         start;
  logic [N:0]   data_a;
  logic [N:0]   data_b;
  logic         busy;
  logic         done;
  logic [N:0]   out;
  logic         bout;
`ifdef SUB_OVF_EN
  logic         ovf;

  modport master (output start, data_a, data_b, input busy, done, out, bout, ovf);
  modport slave  (input start, data_a, data_b, output busy, done, out, bout, ovf);
`else
  modport master (output start, data_a, data_b, input busy, done, out, bout);
  modport slave  (input start, data_a, data_b, output busy, done, out, bout);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial (LSB first) N+1-bit subtractor: IDLE -> SHIFT (N+1 cycles) -> DONE.
// Optional signed-overflow flag enabled by defining SUB_OVF_EN.
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               reset,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = $clog2(N + 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [N:0]       a_sr;
  logic [N:0]       b_sr;
  logic [N-1:0]     res_sr;
  logic [CNT_W-1:0] cnt;
  logic             br;
  logic [N:0]       out_q;
  logic             bout_q;
  logic             d;
  logic             br_nxt;
`ifdef SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
  logic             ovf_q;
`endif

  // Full-subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] sub_bit(input logic a, input logic b, input logic bi);
    return {(~a & b) | (~(a ^ b) & bi), a ^ b ^ bi};
  endfunction

  assign {br_nxt, d} = sub_bit(a_sr[0], b_sr[0], br);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      br     <= 1'b0;
      out_q  <= '0;
      bout_q <= 1'b0;
`ifdef SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.data_a;
            b_sr  <= bus.data_b;
            br    <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
`ifdef SUB_OVF_EN
            a_msb <= bus.data_a[N];
            b_msb <= bus.data_b[N];
`endif
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {d, res_sr[N-1:1]};
          br     <= br_nxt;
          cnt    <= cnt + 1'b1;
          // The last difference bit is still combinational here, so results load from d directly.
          if (cnt == LAST) begin
            state  <= DONE;
            out_q  <= {d, res_sr};
            bout_q <= br_nxt;
`ifdef SUB_OVF_EN
            ovf_q  <= (a_msb != b_msb) && (d != a_msb);
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.out  = out_q;
  assign bus.bout = bout_q;
`ifdef SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (N=4); ovf checks compile in with SUB_OVF_EN.
module tb_serial_subtractor;

  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.N(N)) bus ();

  serial_subtractor #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

`ifdef SUB_OVF_EN
  // Signed reference: overflow when the true difference leaves the N+1-bit range.
  function automatic logic ref_ovf(input logic [N:0] a, input logic [N:0] b);
    int diff;
    diff = int'($signed(a)) - int'($signed(b));
    return (diff > (2**N) - 1) || (diff < -(2**N));
  endfunction
`endif

  // Issue one operation from IDLE and check latency and results.
  task automatic run_op(input string tag, input logic [N:0] a, input logic [N:0] b,
                        input logic [N:0] eo, input logic eb);
    int lat;
    bit seen;
    bus.data_a = a;
    bus.data_b = b;
    bus.start  = 1'b1;
    tick;
    bus.start  = 1'b0;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick;
      lat++;
      if (bus.done) seen = 1'b1;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(N + 1));
    chk({tag, "_out"}, 32'(bus.out), 32'(eo));
    chk({tag, "_bout"}, 32'(bus.bout), 32'(eb));
`ifdef SUB_OVF_EN
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(ref_ovf(a, b)));
`endif
    tick;
    chk({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
  endtask

  logic [N:0] bb_a  [3] = '{5'b01101, 5'b10000, 5'b00000};
  logic [N:0] bb_b  [3] = '{5'b01011, 5'b00001, 5'b00001};
  logic [N:0] bb_o  [3] = '{5'b00010, 5'b01111, 5'b11111};
  logic       bb_br [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    int lat;
    int dones;
    int k;
    int last;
    int cyc;
    logic [N:0] first_out;

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.data_a  = '0;
    bus.data_b  = '0;
    #2 reset    = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_out",  32'(bus.out),  32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    tick;
    tick;
    reset = 1'b1;

    run_op("v_pos",    5'b01101, 5'b01011, 5'b00010, 1'b0);
    run_op("v_neg",    5'b01011, 5'b01101, 5'b11110, 1'b1);
    run_op("v_ovfp",   5'b01111, 5'b10000, 5'b11111, 1'b1);
    run_op("v_zero",   5'b11111, 5'b11111, 5'b00000, 1'b0);
    run_op("v_ovfn",   5'b10000, 5'b00001, 5'b01111, 1'b0);

    // Second start mid-SHIFT with new operands must be ignored.
    bus.data_a = 5'b01101;
    bus.data_b = 5'b01011;
    bus.start  = 1'b1;
    tick;
    bus.start  = 1'b0;
    tick;
    tick;
    chk("mid_hold_out", 32'(bus.out), 32'(5'b01111));
    bus.data_a = 5'b00001;
    bus.data_b = 5'b11111;
    bus.start  = 1'b1;
    tick;
    bus.start  = 1'b0;
    bus.data_a = 5'b10101;
    bus.data_b = 5'b01010;
    lat       = 3;
    dones     = 0;
    first_out = '0;
    for (int i = 0; i < 15; i++) begin
      tick;
      lat++;
      if (bus.done) begin
        dones++;
        if (dones == 1) begin
          first_out = bus.out;
          chk("mid_lat", 32'(lat), 32'(N + 1));
          chk("mid_bout", 32'(bus.bout), 32'd0);
        end
      end
    end
    chk("mid_out", 32'(first_out), 32'(5'b00010));
    chk("mid_ndone", 32'(dones), 32'd1);
    chk("mid_out_stable", 32'(bus.out), 32'(5'b00010));

    // Reset asserted at SHIFT cycle 2 aborts with no done pulse.
    bus.data_a = 5'b01011;
    bus.data_b = 5'b01101;
    bus.start  = 1'b1;
    tick;
    bus.start  = 1'b0;
    tick;
    tick;
    reset = 1'b0;
    #1;
    chk("ra_out",  32'(bus.out),  32'd0);
    chk("ra_bout", 32'(bus.bout), 32'd0);
    chk("ra_busy", 32'(bus.busy), 32'd0);
    chk("ra_done", 32'(bus.done), 32'd0);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (bus.done) dones++;
    end
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (bus.done || bus.busy) dones++;
    end
    chk("ra_no_done", 32'(dones), 32'd0);
    run_op("ra_after", 5'b00111, 5'b00011, 5'b00100, 1'b0);

    // start held high: three back-to-back operations, N+3 cycles apart.
    bus.data_a = bb_a[0];
    bus.data_b = bb_b[0];
    bus.start  = 1'b1;
    k    = 0;
    last = 0;
    cyc  = 0;
    for (int i = 0; i < 40 && k < 3; i++) begin
      tick;
      cyc++;
      if (bus.done) begin
        chk($sformatf("bb%0d_out", k),  32'(bus.out),  32'(bb_o[k]));
        chk($sformatf("bb%0d_bout", k), 32'(bus.bout), 32'(bb_br[k]));
`ifdef SUB_OVF_EN
        chk($sformatf("bb%0d_ovf", k),  32'(bus.ovf),  32'(ref_ovf(bb_a[k], bb_b[k])));
`endif
        if (k == 0) chk("bb_first_lat", 32'(cyc), 32'(N + 2));
        else        chk($sformatf("bb%0d_gap", k), 32'(cyc - last), 32'(N + 3));
        last = cyc;
        k++;
        if (k < 3) begin
          bus.data_a = bb_a[k];
          bus.data_b = bb_b[k];
        end else begin
          bus.start = 1'b0;
        end
      end else if (k > 0 && bus.busy) begin
        chk($sformatf("bb%0d_hold", k), 32'(bus.out), 32'(bb_o[k-1]));
      end
    end
    chk("bb_count", 32'(k), 32'd3);
    bus.start = 1'b0;
    tick;
    tick;
    chk("bb_idle_busy", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter N, default 4; operands and result are N+1 bits wide ([N:0]).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port data_a, input, [N:0]: minuend, captured when start is accepted.
REQ-006 The block SHALL have port data_b, input, [N:0]: subtrahend, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in SHIFT.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking out/bout valid.
REQ-009 The block SHALL have port out, output, [N:0]: difference (data_a - data_b) mod 2^(N+1).
REQ-010 The block SHALL have port bout, output, 1 bit: final borrow; 1 when unsigned data_a < data_b.
REQ-011 The block SHALL have port ovf, output, 1 bit, present only with SUB_OVF_EN: signed two's-complement overflow.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1 at an edge SHALL load the A and B shift registers and clear the borrow FF and bit counter, then go to SHIFT.
REQ-014 SHIFT SHALL process one bit per cycle, LSB first: d = a0^b0^br; br_next = (~a0&b0) | (~(a0^b0)&br).
REQ-015 Each d SHALL be shifted into the MSB of the internal result register while A and B shift right.
REQ-016 After exactly N+1 SHIFT cycles the FSM SHALL enter DONE and load out, bout (and ovf) from the final result and borrow on that same edge.
REQ-017 Latency: with start accepted at edge t, done SHALL be high from edge t+N+1 to edge t+N+2.
REQ-018 DONE SHALL last one cycle and return to IDLE unconditionally.
REQ-019 start in SHIFT or DONE SHALL be ignored with no effect on operands or result.
REQ-020 out, bout and ovf SHALL hold their values until the next DONE; they do not change during SHIFT.
REQ-021 Back-to-back operation: start held high SHALL begin a new operation on the first IDLE edge after DONE, one new operation every N+3 cycles.
REQ-022 data_a and data_b changes after capture SHALL have no effect on the operation in progress.

Reset
REQ-023 reset=0 SHALL force state IDLE and clear busy, done, out, bout, ovf, borrow, counter and shift registers immediately, regardless of clk.
REQ-024 reset asserted mid-SHIFT SHALL abort the operation with no done pulse; after release the block SHALL be in IDLE awaiting start.
REQ-025 The first start after reset release SHALL be accepted on the first rising edge at which reset=1 and start=1.

Configuration
REQ-026 With macro SUB_OVF_EN defined, the ovf port and logic SHALL exist: ovf = (a_msb != b_msb) && (out[N] != a_msb), using operand MSBs captured at start, updated in DONE.
REQ-027 With SUB_OVF_EN undefined, ovf SHALL be absent and the remaining ports and timing SHALL be unchanged.

Verification
REQ-028 N=4, data_a=01101, data_b=01011, start -> done at t+5, out=00010, bout=0, ovf=0.
REQ-029 N=4, data_a=01011, data_b=01101 -> out=11110, bout=1, ovf=0.
REQ-030 N=4 with SUB_OVF_EN, data_a=01111, data_b=10000 -> out=11111, bout=1, ovf=1.
REQ-031 start pulsed again mid-SHIFT with different operands -> ignored; first result unchanged; exactly one done.
REQ-032 reset driven low at SHIFT cycle 2 -> outputs 0 immediately, no done; after release, 00111-00011 -> out=00100, bout=0.
REQ-033 start held high for 3 operations -> done pulses exactly N+3=7 cycles apart, each result correct.
